// File: rtl/wt_axi_mem_responder_if.sv
// AXI4 channel bundle between the write-through cache subsystem (master side)
// and the on-chip memory responder (slave side).
//
// Handshake semantics on every channel: a transfer happens on the rising clock
// edge where both valid and ready are high. Once valid is raised, the sender
// keeps valid and the payload stable until that edge. ready may rise or fall
// at any time and never depends on valid combinationally.
//
// Channels: AW (write address + atop), W (write data/strobe/last),
//           B (write response), AR (read address), R (read data).
// Modports: master (cache side / testbench), slave (memory responder).
interface wt_axi_mem_responder_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 1
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  // AW channel
  logic                 aw_valid;
  logic                 aw_ready;
  logic [IdWidth-1:0]   aw_id;
  logic [AddrWidth-1:0] aw_addr;
  logic [7:0]           aw_len;
  logic [2:0]           aw_size;
  logic [1:0]           aw_burst;
  logic [5:0]           aw_atop;
  // W channel
  logic                 w_valid;
  logic                 w_ready;
  logic [DataWidth-1:0] w_data;
  logic [StrbWidth-1:0] w_strb;
  logic                 w_last;
  // B channel
  logic                 b_valid;
  logic                 b_ready;
  logic [IdWidth-1:0]   b_id;
  logic [1:0]           b_resp;
  logic [UserWidth-1:0] b_user;
  // AR channel
  logic                 ar_valid;
  logic                 ar_ready;
  logic [IdWidth-1:0]   ar_id;
  logic [AddrWidth-1:0] ar_addr;
  logic [7:0]           ar_len;
  logic [2:0]           ar_size;
  logic [1:0]           ar_burst;
  logic [UserWidth-1:0] ar_user;
  // R channel
  logic                 r_valid;
  logic                 r_ready;
  logic [IdWidth-1:0]   r_id;
  logic [DataWidth-1:0] r_data;
  logic [1:0]           r_resp;
  logic                 r_last;
  logic [UserWidth-1:0] r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_atop,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_atop,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );
endinterface

// File: rtl/wt_axi_mem_responder.sv
// AXI4 memory responder for the write-through cache subsystem. One
// word-addressed array served by an independent read FSM (I$ refills, D$
// misses, AMO reads) and write FSM (write-buffer stores).
//
// Ports:
//   clk_i      clock, all state on the rising edge
//   rst_ni     asynchronous active-low reset (memory contents are kept)
//   axi        slave side of the AXI4 bundle
//   r_state_o  read FSM state (0 idle, 1 wait, 2 data)
//   w_state_o  write FSM state (0 idle, 1 data, 2 resp)
module wt_axi_mem_responder #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned UserWidth   = 1,
  parameter int unsigned MemWords    = 1024,
  parameter int unsigned RespLatency = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wt_axi_mem_responder_if.slave axi,
  output logic [1:0]            r_state_o,
  output logic [1:0]            w_state_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = $clog2(MemWords);
  localparam logic [3:0]  LatInit   = (RespLatency == 0) ? 4'd0 : 4'(RespLatency - 1);

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

  // Address of the following beat. WRAP keeps the bits above the wrap window
  // and lets only the bits inside it roll over.
  function automatic logic [AddrWidth-1:0] next_addr(
    input logic [AddrWidth-1:0] addr,
    input logic [7:0]           len,
    input logic [2:0]           size,
    input logic [1:0]           burst
  );
    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] nxt;
    step      = AddrWidth'(1) << size;
    wrap_mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
    case (burst)
      BurstIncr: nxt = addr + step;
      BurstWrap: nxt = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:   nxt = addr;  // FIXED and reserved bursts do not move
    endcase
    return nxt;
  endfunction

  logic [DataWidth-1:0] mem_q [MemWords];

  // ---------------------------------------------------------------- read side
  r_state_e             r_state_q;
  logic [3:0]           r_cnt_q;
  logic [7:0]           r_beat_q;
  logic [AddrWidth-1:0] r_addr_q;
  logic [AddrWidth-1:0] r_addr_d;
  logic [7:0]           r_len_q;
  logic [2:0]           r_size_q;
  logic [1:0]           r_burst_q;
  logic                 ar_ready_q;
  logic                 r_valid_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [UserWidth-1:0] r_user_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic                 r_last_q;
  logic                 r_rsvd;

  assign r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
  assign r_rsvd   = (r_burst_q == BurstRsvd);

  // R payload is registered: the word is sampled at the edge the beat is
  // loaded, so a same-cycle write to that word is only seen by later beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      r_cnt_q    <= '0;
      r_beat_q   <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_size_q   <= '0;
      r_burst_q  <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_user_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (axi.ar_valid && ar_ready_q) begin
            ar_ready_q <= 1'b0;
            r_addr_q   <= axi.ar_addr;
            r_len_q    <= axi.ar_len;
            r_size_q   <= axi.ar_size;
            r_burst_q  <= axi.ar_burst;
            r_id_q     <= axi.ar_id;
            r_user_q   <= axi.ar_user;
            r_beat_q   <= '0;
            if (RespLatency == 0) begin
              r_state_q <= R_DATA;
              r_valid_q <= 1'b1;
              r_data_q  <= (axi.ar_burst == BurstRsvd) ? '0 : mem_q[axi.ar_addr[OffW +: IdxW]];
              r_resp_q  <= (axi.ar_burst == BurstRsvd) ? RespSlvErr : RespOkay;
              r_last_q  <= (axi.ar_len == 8'd0);
            end else begin
              r_state_q <= R_WAIT;
              r_cnt_q   <= LatInit;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt_q == 4'd0) begin
            r_state_q <= R_DATA;
            r_valid_q <= 1'b1;
            r_data_q  <= r_rsvd ? '0 : mem_q[r_addr_q[OffW +: IdxW]];
            r_resp_q  <= r_rsvd ? RespSlvErr : RespOkay;
            r_last_q  <= (r_len_q == 8'd0);
          end else begin
            r_cnt_q <= r_cnt_q - 4'd1;
          end
        end
        R_DATA: begin
          if (axi.r_ready) begin
            if (r_last_q) begin
              r_state_q  <= R_IDLE;
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
            end else begin
              r_beat_q <= r_beat_q + 8'd1;
              r_addr_q <= r_addr_d;
              r_data_q <= r_rsvd ? '0 : mem_q[r_addr_d[OffW +: IdxW]];
              r_last_q <= ((r_beat_q + 8'd1) == r_len_q);
            end
          end
        end
        default: begin
          r_state_q  <= R_IDLE;
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  w_state_e             w_state_q;
  logic [7:0]           w_beat_q;
  logic [AddrWidth-1:0] w_addr_q;
  logic [AddrWidth-1:0] w_addr_d;
  logic [7:0]           w_len_q;
  logic [2:0]           w_size_q;
  logic [1:0]           w_burst_q;
  logic [5:0]           w_atop_q;
  logic [IdWidth-1:0]   w_id_q;
  logic                 w_err_q;
  logic                 aw_ready_q;
  logic                 w_ready_q;
  logic                 b_valid_q;
  logic [IdWidth-1:0]   b_id_q;
  logic [1:0]           b_resp_q;
  logic                 w_hs;
  logic                 w_at_end;
  logic                 w_block;
  logic                 w_beat_err;

  assign w_addr_d   = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
  assign w_hs       = axi.w_valid && w_ready_q;
  assign w_at_end   = (w_beat_q == w_len_q);
  // Atomics are not executed here and reserved bursts have no defined
  // address sequence: both are answered with SLVERR and leave memory alone.
  assign w_block    = (w_burst_q == BurstRsvd) || (w_atop_q != 6'd0);
  assign w_beat_err = (axi.w_last != w_at_end) || w_block;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      w_beat_q   <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_atop_q   <= '0;
      w_id_q     <= '0;
      w_err_q    <= 1'b0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (axi.aw_valid && aw_ready_q) begin
            w_state_q  <= W_DATA;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_addr_q   <= axi.aw_addr;
            w_len_q    <= axi.aw_len;
            w_size_q   <= axi.aw_size;
            w_burst_q  <= axi.aw_burst;
            w_atop_q   <= axi.aw_atop;
            w_id_q     <= axi.aw_id;
            w_beat_q   <= '0;
            w_err_q    <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr_q <= w_addr_d;
            w_beat_q <= w_beat_q + 8'd1;
            w_err_q  <= w_err_q || w_beat_err;
            // Leave on whichever comes first: the master's last flag or the
            // beat count announced on AW.
            if (axi.w_last || w_at_end) begin
              w_state_q <= W_RESP;
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_id_q    <= w_id_q;
              b_resp_q  <= (w_err_q || w_beat_err) ? RespSlvErr : RespOkay;
            end
          end
        end
        W_RESP: begin
          if (axi.b_ready) begin
            w_state_q  <= W_IDLE;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
          end
        end
        default: begin
          w_state_q  <= W_IDLE;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Array is not reset; a reset in the middle of a burst keeps bytes already
  // written because w_ready drops with the FSM state.
  always_ff @(posedge clk_i) begin
    if (w_hs && !w_block) begin
      for (int i = 0; i < int'(StrbWidth); i++) begin
        if (axi.w_strb[i]) begin
          mem_q[w_addr_q[OffW +: IdxW]][8*i +: 8] <= axi.w_data[8*i +: 8];
        end
      end
    end
  end

  assign axi.ar_ready = ar_ready_q;
  assign axi.r_valid  = r_valid_q;
  assign axi.r_id     = r_id_q;
  assign axi.r_data   = r_data_q;
  assign axi.r_resp   = r_resp_q;
  assign axi.r_last   = r_last_q;
  assign axi.r_user   = r_user_q;
  assign axi.aw_ready = aw_ready_q;
  assign axi.w_ready  = w_ready_q;
  assign axi.b_valid  = b_valid_q;
  assign axi.b_id     = b_id_q;
  assign axi.b_resp   = b_resp_q;
  assign axi.b_user   = '0;

  assign r_state_o = r_state_q;
  assign w_state_o = w_state_q;
endmodule

// File: tb/tb_wt_axi_mem_responder.sv
// Bench for wt_axi_mem_responder: directed scenarios followed by randomized
// bursts, checked against an array-based memory model with beat addresses
// computed arithmetically from the burst rules.
module tb_wt_axi_mem_responder;
  localparam int AW        = 64;
  localparam int DW        = 64;
  localparam int IW        = 4;
  localparam int UW        = 1;
  localparam int MEM_WORDS = 1024;
  localparam int RESP_LAT  = 2;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wt_axi_mem_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW)) axi_bus ();
  logic [1:0] r_state;
  logic [1:0] w_state;

  wt_axi_mem_responder #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW),
    .MemWords(MEM_WORDS), .RespLatency(RESP_LAT)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .axi      (axi_bus),
    .r_state_o(r_state),
    .w_state_o(w_state)
  );

  // ------------------------------------------------------------ scoreboard
  logic [DW-1:0] mem_model [MEM_WORDS];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wd_q[$];
  logic [7:0]    ws_q[$];
  logic [DW-1:0] last_rdata;
  logic [1:0]    last_bresp;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_addr(input logic [63:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    logic [63:0] step, ws, lower, res;
    step  = 64'd1 << size;
    ws    = (64'(len) + 64'd1) * step;
    lower = start - (start % ws);
    case (burst)
      2'b01:   res = start + 64'(i) * step;
      2'b10:   res = lower + (((start - lower) + 64'(i) * step) % ws);
      default: res = start;
    endcase
    return res;
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) % 64'(MEM_WORDS));
  endfunction

  // --------------------------------------------------------------- drivers
  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic ar_send(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input logic user);
    int t;
    axi_bus.ar_addr  = addr;
    axi_bus.ar_len   = len;
    axi_bus.ar_size  = size;
    axi_bus.ar_burst = burst;
    axi_bus.ar_id    = id;
    axi_bus.ar_user  = user;
    axi_bus.ar_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!axi_bus.ar_ready && t < 50) begin @(negedge clk); t++; end
    check_eq("ar_ready", 64'(axi_bus.ar_ready), 64'd1);
    @(posedge clk);
    #1 axi_bus.ar_valid = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic user,
                          input int rr_mode);
    logic [DW-1:0] exp_d, hold_d;
    logic [1:0]    exp_r;
    logic          hold_v, hold_l;
    int beat, cyc, lat;
    exp_q.delete();
    rd_q.delete();
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back((burst == 2'b11) ? '0 : mem_model[widx(beat_addr(addr, len, size, burst, i))]);
    exp_r = (burst == 2'b11) ? 2'b10 : 2'b00;
    ar_send(addr, len, size, burst, id, user);
    beat = 0; cyc = 0; lat = 0; hold_v = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beat <= int'(len) && cyc < 100) begin
      case (rr_mode)
        0:       axi_bus.r_ready = 1'b1;
        1:       axi_bus.r_ready = (cyc % 2 == 1);
        default: axi_bus.r_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      cyc++;
      if (axi_bus.r_valid) begin
        if (lat == 0) begin
          lat = cyc;
          check_eq("r_latency", 64'(lat), 64'(RESP_LAT + 1));
        end
        if (hold_v) begin
          check_eq("r_hold_data", axi_bus.r_data, hold_d);
          check_eq("r_hold_last", 64'(axi_bus.r_last), 64'(hold_l));
        end
        if (axi_bus.r_ready) begin
          exp_d = exp_q.pop_front();
          check_eq("r_data", axi_bus.r_data, exp_d);
          check_eq("r_resp", 64'(axi_bus.r_resp), 64'(exp_r));
          check_eq("r_last", 64'(axi_bus.r_last), 64'(beat == int'(len)));
          check_eq("r_id", 64'(axi_bus.r_id), 64'(id));
          check_eq("r_user", 64'(axi_bus.r_user), 64'(user));
          rd_q.push_back(axi_bus.r_data);
          last_rdata = axi_bus.r_data;
          beat++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_d = axi_bus.r_data;
          hold_l = axi_bus.r_last;
        end
      end else if (hold_v) begin
        check_eq("r_valid_held", 64'(axi_bus.r_valid), 64'd1);
        hold_v = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    axi_bus.r_ready = 1'b0;
    check_eq("r_beats", 64'(beat), 64'(len) + 64'd1);
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] atop, input logic [3:0] id,
                           input int last_at, input bit rand_strb);
    logic [DW-1:0] d;
    logic [7:0]    s;
    logic [63:0]   a;
    logic          exp_err;
    int t, lat;
    exp_err = (last_at != int'(len)) || (atop != 6'd0) || (burst == 2'b11);
    axi_bus.aw_addr  = addr;
    axi_bus.aw_len   = len;
    axi_bus.aw_size  = size;
    axi_bus.aw_burst = burst;
    axi_bus.aw_atop  = atop;
    axi_bus.aw_id    = id;
    axi_bus.aw_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!axi_bus.aw_ready && t < 50) begin @(negedge clk); t++; end
    check_eq("aw_ready", 64'(axi_bus.aw_ready), 64'd1);
    @(posedge clk);
    #1 axi_bus.aw_valid = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      if (wd_q.size() > 0) begin
        d = wd_q.pop_front();
        s = ws_q.pop_front();
      end else begin
        d = {$urandom, $urandom};
        s = rand_strb ? 8'($urandom) : 8'hFF;
      end
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      axi_bus.w_valid = 1'b1;
      axi_bus.w_data  = d;
      axi_bus.w_strb  = s;
      axi_bus.w_last  = (i == last_at);
      t = 0;
      @(negedge clk);
      while (!axi_bus.w_ready && t < 50) begin @(negedge clk); t++; end
      check_eq("w_ready", 64'(axi_bus.w_ready), 64'd1);
      @(posedge clk);
      if (atop == 6'd0 && burst != 2'b11) begin
        a = beat_addr(addr, len, size, burst, i);
        for (int k = 0; k < 8; k++)
          if (s[k]) mem_model[widx(a)][8*k +: 8] = d[8*k +: 8];
      end
      #1;
      axi_bus.w_valid = 1'b0;
      axi_bus.w_last  = 1'b0;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!axi_bus.b_valid && lat < 50);
    check_eq("b_latency", 64'(lat), 64'd1);
    check_eq("b_id", 64'(axi_bus.b_id), 64'(id));
    check_eq("b_resp", 64'(axi_bus.b_resp), exp_err ? 64'd2 : 64'd0);
    check_eq("b_user", 64'(axi_bus.b_user), 64'd0);
    last_bresp = axi_bus.b_resp;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("b_hold", 64'(axi_bus.b_valid), 64'd1);
    end
    axi_bus.b_ready = 1'b1;
    @(posedge clk);
    #1 axi_bus.b_ready = 1'b0;
  endtask

  // -------------------------------------------------------------- stimulus
  logic [DW-1:0] saved;
  logic [1:0]    rb;
  logic [7:0]    rlen;
  logic [63:0]   raddr;
  int            r, last_at;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_model[i] = '0;
    axi_bus.aw_valid = 0; axi_bus.aw_id = 0; axi_bus.aw_addr = 0; axi_bus.aw_len = 0;
    axi_bus.aw_size = 0; axi_bus.aw_burst = 0; axi_bus.aw_atop = 0;
    axi_bus.w_valid = 0; axi_bus.w_data = 0; axi_bus.w_strb = 0; axi_bus.w_last = 0;
    axi_bus.b_ready = 0;
    axi_bus.ar_valid = 0; axi_bus.ar_id = 0; axi_bus.ar_addr = 0; axi_bus.ar_len = 0;
    axi_bus.ar_size = 0; axi_bus.ar_burst = 0; axi_bus.ar_user = 0;
    axi_bus.r_ready = 0;
    last_rdata = '0;
    last_bresp = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ar_ready", 64'(axi_bus.ar_ready), 64'd1);
    check_eq("rst_aw_ready", 64'(axi_bus.aw_ready), 64'd1);
    check_eq("rst_w_ready",  64'(axi_bus.w_ready),  64'd0);
    check_eq("rst_r_valid",  64'(axi_bus.r_valid),  64'd0);
    check_eq("rst_b_valid",  64'(axi_bus.b_valid),  64'd0);
    check_eq("rst_r_data",   axi_bus.r_data,        64'd0);
    check_eq("rst_r_last",   64'(axi_bus.r_last),   64'd0);
    check_eq("rst_b_resp",   64'(axi_bus.b_resp),   64'd0);
    @(posedge clk);
    #1;

    // W offered before any AW is held off
    axi_bus.w_valid = 1'b1;
    axi_bus.w_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    axi_bus.w_strb  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check_eq("w_ready_no_aw", 64'(axi_bus.w_ready), 64'd0);
    end
    @(posedge clk);
    #1 axi_bus.w_valid = 1'b0;

    // Fill words 0..63 so every later read sees defined data
    axi_write(64'h0, 8'd63, 3'd3, 2'b01, 6'd0, 4'd1, 63, 1'b0);

    // Single write then read
    wd_q.push_back(64'h1122_3344_5566_7788); ws_q.push_back(8'hFF);
    axi_write(64'h80, 8'd0, 3'd3, 2'b01, 6'd0, 4'd2, 0, 1'b0);
    check_eq("single_bresp", 64'(last_bresp), 64'd0);
    axi_read(64'h80, 8'd0, 3'd3, 2'b01, 4'd3, 1'b0, 0);
    check_eq("single_rdata", last_rdata, 64'h1122_3344_5566_7788);

    // Refill-style read with r_ready toggling
    axi_read(64'h100, 8'd1, 3'd3, 2'b01, 4'd5, 1'b1, 1);
    check_eq("refill_beat0", rd_q[0], mem_model[32]);
    check_eq("refill_beat1", rd_q[1], mem_model[33]);

    // Partial strobe merge
    wd_q.push_back('1); ws_q.push_back(8'hFF);
    axi_write(64'h40, 8'd0, 3'd3, 2'b01, 6'd0, 4'd4, 0, 1'b0);
    wd_q.push_back('0); ws_q.push_back(8'h0F);
    axi_write(64'h40, 8'd0, 3'd3, 2'b01, 6'd0, 4'd4, 0, 1'b0);
    axi_read(64'h40, 8'd0, 3'd3, 2'b01, 4'd4, 1'b0, 0);
    check_eq("strobe_word", last_rdata, 64'hFFFF_FFFF_0000_0000);

    // WRAP len 3 at 0x18 -> words 3,0,1,2
    axi_read(64'h18, 8'd3, 3'd3, 2'b10, 4'd6, 1'b0, 2);
    check_eq("wrap_beat0", rd_q[0], mem_model[3]);
    check_eq("wrap_beat1", rd_q[1], mem_model[0]);
    check_eq("wrap_beat2", rd_q[2], mem_model[1]);
    check_eq("wrap_beat3", rd_q[3], mem_model[2]);

    // Reserved burst, read and write
    axi_read(64'h40, 8'd1, 3'd3, 2'b11, 4'd7, 1'b0, 0);
    check_eq("rsvd_rdata", last_rdata, 64'd0);
    saved = mem_model[9];
    axi_write(64'h48, 8'd0, 3'd3, 2'b11, 6'd0, 4'd7, 0, 1'b0);
    check_eq("rsvd_bresp", 64'(last_bresp), 64'd2);
    axi_read(64'h48, 8'd0, 3'd3, 2'b01, 4'd7, 1'b0, 0);
    check_eq("rsvd_no_write", last_rdata, saved);

    // Atomic request: SLVERR, memory untouched
    saved = mem_model[10];
    axi_write(64'h50, 8'd0, 3'd3, 2'b01, 6'h20, 4'd8, 0, 1'b0);
    check_eq("atop_bresp", 64'(last_bresp), 64'd2);
    axi_read(64'h50, 8'd0, 3'd3, 2'b01, 4'd8, 1'b0, 0);
    check_eq("atop_no_write", last_rdata, saved);

    // Early w_last: len 3, last on beat 1
    axi_write(64'h60, 8'd3, 3'd3, 2'b01, 6'd0, 4'd9, 1, 1'b0);
    check_eq("early_last_bresp", 64'(last_bresp), 64'd2);
    axi_read(64'h60, 8'd3, 3'd3, 2'b01, 4'd9, 1'b0, 0);

    // Reset in the middle of a read burst
    ar_send(64'h0, 8'd3, 3'd3, 2'b01, 4'd10, 1'b0);
    axi_bus.r_ready = 1'b1;
    r = 0;
    @(negedge clk);
    while (!axi_bus.r_valid && r < 20) begin @(negedge clk); r++; end
    check_eq("mid_rst_beat0", axi_bus.r_data, mem_model[0]);
    @(posedge clk);
    #1 axi_bus.r_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_r_valid", 64'(axi_bus.r_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ar_ready", 64'(axi_bus.ar_ready), 64'd1);
    check_eq("post_rst_r_valid", 64'(axi_bus.r_valid), 64'd0);
    @(posedge clk);
    #1;
    axi_read(64'h0, 8'd3, 3'd3, 2'b01, 4'd11, 1'b1, 0);

    // Randomized traffic, including aliased upper address bits
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      rb = (r < 2) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (rb == 2'b10) begin
        r = $urandom_range(0, 2);
        rlen = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : 8'd7;
      end else begin
        rlen = 8'($urandom_range(0, 7));
      end
      raddr = (64'($urandom_range(0, 55)) << 3) | (64'($urandom_range(0, 3)) << 13);
      if ($urandom_range(0, 1) == 1) begin
        last_at = int'(rlen);
        if (rlen != 0 && $urandom_range(0, 7) == 0) last_at = $urandom_range(0, int'(rlen) - 1);
        axi_write(raddr, rlen, 3'($urandom_range(2, 3)), rb,
                  ($urandom_range(0, 9) == 0) ? 6'h20 : 6'd0, 4'($urandom), last_at, 1'b1);
      end else begin
        axi_read(raddr, rlen, 3'($urandom_range(2, 3)), rb, 4'($urandom), 1'($urandom),
                 $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
